mips_bus_mailbox: RTL and testbench
===================================

// Module: mips_bus_mailbox
// PURPOSE
//  Memory-mapped responder on the CPU data bus (address/read/write/waitrequest/
//  writedata/byteenable/readdata). It sits beside cpu_ram as a second bus target.
//  CPU writes to DATA are pushed into a TX FIFO and drained by an external
//  valid/ready stream. An external stream fills an RX FIFO that the CPU pops by
//  reading DATA. Wait states are configurable so benches can exercise CPU stalls.
// PARAMETERS
//  BASE_ADDR    32'h4000_0000  byte base of 16-byte window; bits[3:0] must be 0
//  DEPTH        8              entries per FIFO; power of 2, >= 2, <= 128
//  WAIT_CYCLES  0              cycles waitrequest is held high per bus access
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   synchronous, active-low reset
//  address      in   32  byte address from CPU
//  read         in   1   read request
//  write        in   1   write request (read&write together = protocol error, ignored)
//  waitrequest  out  1   high = access not yet complete; CPU holds request stable
//  writedata    in   32  write data
//  byteenable   in   4   byte lanes of writedata valid
//  readdata     out  32  read data, valid in completion cycle only
//  out_valid    out  1   TX FIFO head valid
//  out_ready    in   1   consumer accepts head this cycle
//  out_data     out  32  TX FIFO head
//  in_valid     in   1   producer offers in_data
//  in_ready     out  1   RX FIFO can accept
//  in_data      in   32  word to push into RX FIFO
// BEHAVIOUR
//  Decode: hit = (address[31:4]==BASE_ADDR[31:4]); offset = address[3:2].
//   +0 DATA: write pushes TX; read pops RX.
//   +4 STATUS (RO): [0]rx_empty [1]tx_full [2]tx_overflow [3]rx_underflow
//      [15:8]rx_count [23:16]tx_count; other bits 0.
//   +8 CONTROL (WO): write with byteenable[0] & writedata[0] clears both FIFOs and flags.
//   +C and miss: writes ignored, reads return 0. Miss still uses the wait FSM.
//  Wait FSM, req = read^write:
//   IDLE: req & WAIT_CYCLES==0 -> complete this cycle (waitrequest=0), stay IDLE.
//         req & WAIT_CYCLES>0  -> waitrequest=1, cnt<=WAIT_CYCLES-1, go WAIT.
//         !req                 -> waitrequest=0.
//   WAIT: cnt!=0 -> waitrequest=1, cnt--. cnt==0 -> waitrequest=0, complete, go IDLE.
//         req dropped in WAIT  -> go IDLE, no side effect.
//   So waitrequest is high for exactly WAIT_CYCLES cycles per access.
//   Back-to-back accesses are legal on the next cycle.
//  Completion: side effects (push/pop/clear) commit at the posedge ending the
//   completion cycle. readdata is combinational in that cycle and 0 otherwise.
//  Byteenable: a TX push stores writedata with disabled lanes forced to 0.
//   A push with byteenable==0 still pushes.
//   Reads ignore byteenable and always return 32 bits.
//  Full TX write: word dropped, tx_overflow set (sticky).
//  Empty RX read: returns 0, rx_underflow set (sticky). No pointer moves.
//  Stream side: out_valid = !tx_empty; out_data = head, 0 when empty.
//   in_ready = !rx_full (no same-cycle pass-through when full).
//   Pop on out_valid&out_ready; push on in_valid&in_ready.
//  Simultaneous events: CPU push and stream pop on the same FIFO in the same cycle
//   both occur, count unchanged. The same holds for stream push and CPU pop.
//   A CONTROL clear overrides all same-cycle pushes and pops.
//  Pointers wrap modulo DEPTH. Counts are clog2(DEPTH)+1 bits, zero-extended
//   into STATUS.
//  Reset (reset==0 at posedge): FSM->IDLE, cnt=0, pointers/counts/flags=0.
//   Resulting outputs: waitrequest=0, readdata=0, out_valid=0, out_data=0, in_ready=1.
//   Reset mid-access aborts it with no side effect.
// TESTING
//  1 WAIT_CYCLES=0: write 0x1234_5678 to +0 -> waitrequest never high;
//    next cycle out_valid=1, out_data=0x1234_5678, STATUS[23:16]=1.
//  2 WAIT_CYCLES=3: read STATUS -> waitrequest high exactly 3 cycles,
//    then readdata=0x0000_0001 (rx_empty) for one cycle.
//  3 Write 0xAABB_CCDD with byteenable=4'b0101 -> out_data=0x00BB_00DD.
//  4 Fill TX with DEPTH writes (out_ready=0), write once more -> STATUS[1]=1,
//    STATUS[2]=1. Drain -> DEPTH words in order, extra word absent.
//    CONTROL write of 1 -> STATUS=0x0000_0001.
//  5 in_valid with 0x11, 0x22; CPU reads +0 twice -> 0x11 then 0x22;
//    third read -> 0, STATUS[3]=1. Repeat the first read while in_valid pushes
//    in the same cycle -> rx_count unchanged.
//  6 reset low during WAIT of a TX write -> no push, waitrequest=0, out_valid=0.

Source files
------------

// File: rtl/mips_bus_mailbox.sv
// CPU data-bus mailbox: TX FIFO filled by CPU writes and drained by a stream,
// RX FIFO filled by a stream and popped by CPU reads, with programmable wait states.
module mips_bus_mailbox #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 32'(WAIT_CYCLES - 1) : '0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           req, done;

  logic [31:0]    tx_mem_q [DEPTH];
  logic [31:0]    tx_mem_d [DEPTH];
  logic [31:0]    rx_mem_q [DEPTH];
  logic [31:0]    rx_mem_d [DEPTH];
  logic [AW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;

  logic           hit;
  logic [1:0]     offset;
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic           cpu_push, cpu_pop, clear;
  logic           tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0]    be_mask, status;
  logic           unused_bits;

  // Wait-state sequencer: holds waitrequest for WAIT_CYCLES cycles, then completes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waitrequest = 1'b0;
    done        = 1'b0;
    req         = read ^ write;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            done = 1'b1;
          end else begin
            waitrequest = 1'b1;
            cnt_d       = WAIT_LOAD;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          waitrequest = 1'b1;
          cnt_d       = cnt_q - 32'd1;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address decode, FIFO handshakes, STATUS assembly and bus/stream outputs.
  always_comb begin
    hit         = (address[31:4] == BASE_ADDR[31:4]);
    offset      = address[3:2];
    unused_bits = ^address[1:0];
    tx_empty    = (tx_cnt_q == '0);
    tx_full     = (tx_cnt_q == CW'(DEPTH));
    rx_empty    = (rx_cnt_q == '0);
    rx_full     = (rx_cnt_q == CW'(DEPTH));
    cpu_push    = done & write & hit & (offset == 2'd0);
    cpu_pop     = done & read  & hit & (offset == 2'd0);
    clear       = done & write & hit & (offset == 2'd2) & byteenable[0] & writedata[0];
    tx_push     = cpu_push & ~tx_full;
    tx_pop      = ~tx_empty & out_ready;
    rx_push     = in_valid & ~rx_full;
    rx_pop      = cpu_pop & ~rx_empty;
    be_mask     = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
    status      = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 4'h0, unf_q, ovf_q, tx_full, rx_empty};
    readdata    = '0;
    if (done && read && hit) begin
      unique case (offset)
        2'd0:    readdata = rx_empty ? '0 : rx_mem_q[rx_rd_q];
        2'd1:    readdata = status;
        default: readdata = '0;
      endcase
    end
    out_valid = ~tx_empty;
    out_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q];
    in_ready  = ~rx_full;
  end

  // FIFO next state; a CONTROL clear overrides every same-cycle push and pop.
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = writedata & be_mask;
      tx_wr_d           = tx_wr_q + AW'(1);
    end
    if (tx_pop)  tx_rd_d = tx_rd_q + AW'(1);
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = in_data;
      rx_wr_d           = rx_wr_q + AW'(1);
    end
    if (rx_pop)  rx_rd_d = rx_rd_q + AW'(1);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    ovf_d    = ovf_q | (cpu_push & tx_full);
    unf_d    = unf_q | (cpu_pop & rx_empty);
    if (clear) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      tx_cnt_d = '0;
      rx_cnt_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

// File: tb/tb_mips_bus_mailbox.sv
// Scoreboard bench for mips_bus_mailbox: queue-based reference model feeds
// expectation queues that a negedge monitor pops and compares.
module tb_mips_bus_mailbox;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WAITC = 3;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] address, writedata, readdata, out_data, in_data;
  logic        read, write, waitrequest, out_valid, out_ready, in_valid, in_ready;
  logic [3:0]  byteenable;

  logic [31:0] z_address, z_writedata, z_readdata, z_out_data, z_in_data;
  logic        z_read, z_write, z_waitrequest, z_out_valid, z_out_ready, z_in_valid, z_in_ready;
  logic [3:0]  z_byteenable;

  mips_bus_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  mips_bus_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_zero (
    .clk(clk), .reset(reset), .address(z_address), .read(z_read), .write(z_write),
    .waitrequest(z_waitrequest), .writedata(z_writedata), .byteenable(z_byteenable),
    .readdata(z_readdata), .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct packed {
    logic        wr;
    logic        ov;
    logic        ir;
    logic [31:0] od;
  } cyc_t;

  cyc_t        exp_cyc[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_out[$];

  // reference model state
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  int unsigned acc_k = 0;

  // stream randomisation controls
  bit          stream_rand = 1'b0;
  int unsigned in_pct = 50, out_pct = 50;

  // values sampled by tick() at the negedge of its cycle
  logic        s_wr, s_ov;
  logic [31:0] s_rd, s_od;

  cyc_t mon_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT presented data with no expectation queued at %0t", name, $time);
  endtask

  function automatic logic [31:0] m_status(input int unsigned txn, input int unsigned rxn);
    return {8'h00, 8'(txn), 8'(rxn), 4'h0, m_unf, m_ovf, (txn == DEPTH), (rxn == 0)};
  endfunction

  // One bus cycle: randomise stream inputs if enabled, predict with the model,
  // sample the DUT at the negedge, advance to just after the next posedge.
  task automatic tick();
    int unsigned txn, rxn;
    logic        req, hit, done, clr;
    logic [1:0]  off;
    logic [31:0] val, mask;
    cyc_t        c;
    if (stream_rand) begin
      in_valid  = ($urandom_range(0, 99) < in_pct);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < out_pct);
    end
    txn  = m_tx.size();
    rxn  = m_rx.size();
    req  = read ^ write;
    hit  = (address[31:4] == BASE[31:4]);
    off  = address[3:2];
    done = req && (acc_k == WAITC);
    c.wr = req && (acc_k < WAITC);
    c.ov = (txn != 0);
    c.ir = (rxn < DEPTH);
    c.od = (txn != 0) ? m_tx[0] : 32'h0;
    exp_cyc.push_back(c);
    if (done && read) begin
      val = 32'h0;
      if (hit && off == 2'd0 && rxn != 0) val = m_rx[0];
      if (hit && off == 2'd1) val = m_status(txn, rxn);
      exp_rd.push_back(val);
    end
    if (txn != 0 && out_ready) exp_out.push_back(m_tx[0]);
    clr = done && write && hit && off == 2'd2 && byteenable[0] && writedata[0];
    if (clr) begin
      m_tx.delete();
      m_rx.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (done && write && hit && off == 2'd0) begin
        mask = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
        if (txn == DEPTH) m_ovf = 1'b1;
        else m_tx.push_back(writedata & mask);
      end
      if (txn != 0 && out_ready) void'(m_tx.pop_front());
      if (done && read && hit && off == 2'd0) begin
        if (rxn == 0) m_unf = 1'b1;
        else void'(m_rx.pop_front());
      end
      if (in_valid && rxn < DEPTH) m_rx.push_back(in_data);
    end
    acc_k = (req && !done) ? acc_k + 1 : 0;
    @(negedge clk);
    s_wr = waitrequest;
    s_rd = readdata;
    s_ov = out_valid;
    s_od = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic [31:0] a, input logic r, input logic w,
                            input logic [31:0] wd, input logic [3:0] be, input int unsigned hold,
                            output logic [31:0] rdata, output int unsigned nwait);
    address = a; read = r; write = w; writedata = wd; byteenable = be;
    rdata = 32'h0;
    nwait = 0;
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      if (s_wr) nwait++;
      else rdata = s_rd;
    end
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Monitor: per-cycle flags, plus read completions and stream transfers as they appear.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (exp_cyc.size() != 0) begin
        mon_c = exp_cyc.pop_front();
        check("waitrequest", 32'(waitrequest), 32'(mon_c.wr));
        check("out_valid", 32'(out_valid), 32'(mon_c.ov));
        check("in_ready", 32'(in_ready), 32'(mon_c.ir));
        check("out_data", out_data, mon_c.od);
      end
      if (read && !write && !waitrequest) begin
        if (exp_rd.size() == 0) flag_fail("readdata_unexpected");
        else check("readdata", readdata, exp_rd.pop_front());
      end else begin
        check("readdata_idle", readdata, 32'h0);
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) flag_fail("stream_out_unexpected");
        else check("stream_out", out_data, exp_out.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] rd, a, wd;
    int unsigned nw, r;
    logic [31:0] words[DEPTH];

    reset = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    z_address = '0; z_read = 1'b0; z_write = 1'b0; z_writedata = '0; z_byteenable = '0;
    z_out_ready = 1'b0; z_in_valid = 1'b0; z_in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_waitrequest", 32'(waitrequest), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_readdata", readdata, 32'h0);
    @(posedge clk); #1;

    // zero-wait instance: single-cycle write, then STATUS, then same-cycle RX push+pop
    z_address = BASE; z_write = 1'b1; z_writedata = 32'h1234_5678; z_byteenable = 4'hF;
    @(negedge clk);
    check("z_write_waitrequest", 32'(z_waitrequest), 32'h0);
    @(posedge clk); #1;
    z_write = 1'b0;
    @(negedge clk);
    check("z_out_valid", 32'(z_out_valid), 32'h1);
    check("z_out_data", z_out_data, 32'h1234_5678);
    @(posedge clk); #1;
    z_address = BASE + 32'h4; z_read = 1'b1;
    @(negedge clk);
    check("z_status_wait", 32'(z_waitrequest), 32'h0);
    check("z_status_txcount", z_readdata, 32'h0001_0001);
    @(posedge clk); #1;
    z_read = 1'b0; z_in_valid = 1'b1; z_in_data = 32'h33;
    @(posedge clk); #1;
    z_address = BASE; z_read = 1'b1; z_in_data = 32'h44;
    @(negedge clk);
    check("z_pop_with_push", z_readdata, 32'h33);
    @(posedge clk); #1;
    z_in_valid = 1'b0; z_address = BASE + 32'h4;
    @(negedge clk);
    check("z_rxcount_unchanged", z_readdata, 32'h0001_0100);
    @(posedge clk); #1;
    z_read = 1'b0;

    // STATUS read with wait states
    cpu_access(BASE + 32'h4, 1'b1, 1'b0, '0, 4'hF, WAITC + 1, rd, nw);
    check("t2_wait_cycles", nw, WAITC);
    check("t2_status", rd, 32'h0000_0001);

    // byte-lane masking on push
    cpu_access(BASE, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101, WAITC + 1, rd, nw);
    tick();
    check("t3_masked_head", s_od, 32'h00BB_00DD);
    cpu_access(BASE + 32'h8, 1'b0, 1'b1, 32'h1, 4'h1, WAITC + 1, rd, nw);

    // TX fill, overflow, drain in order, clear
    for (int unsigned i = 0; i < DEPTH; i++) begin
      words[i] = 32'hC0DE_0000 + 32'(i * 17);
      cpu_access(BASE, 1'b0, 1'b1, words[i], 4'hF, WAITC + 1, rd, nw);
    end
    cpu_access(BASE, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, WAITC + 1, rd, nw);
    cpu_access(BASE + 32'h4, 1'b1, 1'b0, '0, 4'hF, WAITC + 1, rd, nw);
    check("t4_full_status", rd, 32'h0008_0007);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tick();
      check("t4_drain_word", s_od, words[i]);
    end
    out_ready = 1'b0;
    tick();
    check("t4_drained_valid", 32'(s_ov), 32'h0);
    cpu_access(BASE + 32'h8, 1'b0, 1'b1, 32'h1, 4'h1, WAITC + 1, rd, nw);
    cpu_access(BASE + 32'h4, 1'b1, 1'b0, '0, 4'hF, WAITC + 1, rd, nw);
    check("t4_clear_status", rd, 32'h0000_0001);

    // RX push/pop order and underflow
    in_valid = 1'b1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_valid = 1'b0;
    cpu_access(BASE, 1'b1, 1'b0, '0, 4'h0, WAITC + 1, rd, nw);
    check("t5_first", rd, 32'h11);
    cpu_access(BASE, 1'b1, 1'b0, '0, 4'h0, WAITC + 1, rd, nw);
    check("t5_second", rd, 32'h22);
    cpu_access(BASE, 1'b1, 1'b0, '0, 4'h0, WAITC + 1, rd, nw);
    check("t5_empty_read", rd, 32'h0);
    cpu_access(BASE + 32'h4, 1'b1, 1'b0, '0, 4'hF, WAITC + 1, rd, nw);
    check("t5_underflow_status", rd, 32'h0000_0009);
    cpu_access(BASE + 32'h8, 1'b0, 1'b1, 32'h1, 4'h1, WAITC + 1, rd, nw);

    // reset during the wait of a TX write
    address = BASE; write = 1'b1; writedata = 32'h5555_AAAA; byteenable = 4'hF;
    tick();
    tick();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; write = 1'b0;
    m_tx.delete(); m_rx.delete(); m_ovf = 1'b0; m_unf = 1'b0; acc_k = 0;
    tick();
    check("t6_waitrequest", 32'(s_wr), 32'h0);
    check("t6_out_valid", 32'(s_ov), 32'h0);

    // randomised traffic in three load mixes
    stream_rand = 1'b1;
    for (int unsigned ph = 0; ph < 3; ph++) begin
      in_pct  = (ph == 0) ? 70 : (ph == 1) ? 15 : 50;
      out_pct = (ph == 0) ? 15 : (ph == 1) ? 80 : 50;
      for (int unsigned n = 0; n < 250; n++) begin
        r  = $urandom_range(0, 99);
        wd = $urandom;
        a  = BASE | 32'($urandom_range(0, 3));
        if (r < 35)      cpu_access(a, 1'b0, 1'b1, wd, 4'($urandom), WAITC + 1, rd, nw);
        else if (r < 60) cpu_access(a, 1'b1, 1'b0, wd, 4'($urandom), WAITC + 1, rd, nw);
        else if (r < 72) cpu_access(a | 32'h4, 1'b1, 1'b0, wd, 4'hF, WAITC + 1, rd, nw);
        else if (r < 76) cpu_access(a | 32'h8, 1'b0, 1'b1, wd, 4'($urandom), WAITC + 1, rd, nw);
        else if (r < 80) cpu_access(a | 32'h8, 1'b1, 1'b0, wd, 4'hF, WAITC + 1, rd, nw);
        else if (r < 85) cpu_access(a | 32'hC, 1'($urandom), 1'b0, wd, 4'hF, WAITC + 1, rd, nw);
        else if (r < 90) cpu_access(BASE + 32'h10 + {20'h0, 8'($urandom), 4'h0},
                                    1'b1, 1'b0, wd, 4'hF, WAITC + 1, rd, nw);
        else if (r < 95) cpu_access(a & 32'hFFFF_FFF3, 1'($urandom), 1'b1, wd, 4'hF,
                                    $urandom_range(1, WAITC), rd, nw);
        else             cpu_access(a & 32'hFFFF_FFF3, 1'b1, 1'b1, wd, 4'hF, 1, rd, nw);
        idle($urandom_range(0, 2));
      end
    end

    // drain and confirm nothing predicted went unobserved
    stream_rand = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(DEPTH + 2);
    check("exp_rd_leftover", exp_rd.size(), 32'h0);
    check("exp_out_leftover", exp_out.size(), 32'h0);
    check("exp_cyc_leftover", exp_cyc.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
